ahb_iopmp_resp: RTL



---
 rtl/ahb_iopmp_resp.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ahb_iopmp_resp.sv
// ahb_iopmp_resp: converts IOPMP-denied AHB transfers into a two-cycle ERROR
// response to the master and logs each violation in a small FIFO for software.
module ahb_iopmp_resp #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LOG_DEPTH  = 4
) (
  input  logic                            hclk,
  input  logic                            hreset,
  input  logic [ADDR_WIDTH-1:0]           s_haddr,
  input  logic [1:0]                      s_htrans,
  input  logic                            s_hwrite,
  input  logic [2:0]                      s_hsize,
  input  logic                            deny,
  input  logic [1:0]                      m_hresp,
  input  logic                            m_hready,
  input  logic [DATA_WIDTH-1:0]           m_hrdata,
  output logic [1:0]                      s_hresp,
  output logic                            s_hready,
  output logic [DATA_WIDTH-1:0]           s_hrdata,
  input  logic                            log_pop,
  input  logic                            log_clr,
  output logic                            log_valid,
  output logic [ADDR_WIDTH-1:0]           log_addr,
  output logic                            log_write,
  output logic [2:0]                      log_size,
  output logic [$clog2(LOG_DEPTH):0]      log_count,
  output logic                            log_ovf,
  output logic                            irq
);

  localparam int PTR_W = $clog2(LOG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_PASS = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Violation log storage (head is at r_rptr)
  logic [ADDR_WIDTH-1:0] r_mem_addr  [LOG_DEPTH];
  logic                  r_mem_write [LOG_DEPTH];
  logic [2:0]            r_mem_size  [LOG_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_ovf;
  logic [ADDR_WIDTH-1:0] r_log_addr;
  logic                  r_log_write;
  logic [2:0]            r_log_size;

  logic                  w_active;
  logic                  w_viol;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_push;
  logic                  w_ovf_set;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [PTR_W-1:0]      w_rptr_nxt;
  logic [PTR_W-1:0]      w_wptr_nxt;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic                  w_head_write;
  logic [2:0]            w_head_size;

  // Response mux: pass downstream through in PASS, drive the two ERROR beats otherwise
  always_comb begin
    s_hresp  = m_hresp;
    s_hready = m_hready;
    s_hrdata = m_hrdata;
    case (r_state)
      ST_PASS: begin
        s_hresp  = m_hresp;
        s_hready = m_hready;
        s_hrdata = m_hrdata;
      end
      ST_ERR1: begin
        s_hresp  = HRESP_ERROR;
        s_hready = 1'b0;
        s_hrdata = '0;
      end
      ST_ERR2: begin
        s_hresp  = HRESP_ERROR;
        s_hready = 1'b1;
        s_hrdata = '0;
      end
      default: begin
        s_hresp  = m_hresp;
        s_hready = m_hready;
        s_hrdata = m_hrdata;
      end
    endcase
  end

  // A violation is a denied address phase that the master sees accepted;
  // in ERR1 hready is low so address-phase inputs are naturally ignored.
  assign w_active = (s_htrans == 2'b10) | (s_htrans == 2'b11);
  assign w_viol   = s_hready & w_active & deny;

  // Next-state decision for the error response sequencer
  always_comb begin
    w_state_nxt = ST_PASS;
    case (r_state)
      ST_PASS: begin
        if (w_viol) w_state_nxt = ST_ERR1;
        else        w_state_nxt = ST_PASS;
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      ST_ERR2: begin
        if (w_viol) w_state_nxt = ST_ERR1;
        else        w_state_nxt = ST_PASS;
      end
      default: w_state_nxt = ST_PASS;
    endcase
  end

  // State register
  always_ff @(posedge hclk) begin
    if (hreset) r_state <= ST_PASS;
    else        r_state <= w_state_nxt;
  end

  // A full log still accepts a push when the head is popped in the same cycle
  assign w_pop     = log_pop & (r_count != {CNT_W{1'b0}});
  assign w_full    = (r_count == CNT_W'(LOG_DEPTH));
  assign w_push    = w_viol & (~w_full | w_pop);
  assign w_ovf_set = w_viol & w_full & ~w_pop;

  // Next occupancy and pointers; a flush wins over any push/pop
  always_comb begin
    w_count_nxt = r_count;
    w_rptr_nxt  = r_rptr;
    w_wptr_nxt  = r_wptr;
    if (log_clr) begin
      w_count_nxt = {CNT_W{1'b0}};
      w_rptr_nxt  = {PTR_W{1'b0}};
      w_wptr_nxt  = {PTR_W{1'b0}};
    end else begin
      if (w_push & ~w_pop)      w_count_nxt = r_count + CNT_W'(1);
      else if (w_pop & ~w_push) w_count_nxt = r_count - CNT_W'(1);
      else                      w_count_nxt = r_count;
      if (w_pop)  w_rptr_nxt = r_rptr + PTR_W'(1);
      else        w_rptr_nxt = r_rptr;
      if (w_push) w_wptr_nxt = r_wptr + PTR_W'(1);
      else        w_wptr_nxt = r_wptr;
    end
  end

  // Next head entry; forwards the incoming push when it becomes the only entry
  always_comb begin
    w_head_addr  = r_log_addr;
    w_head_write = r_log_write;
    w_head_size  = r_log_size;
    if (w_count_nxt != {CNT_W{1'b0}}) begin
      if ((r_count == {CNT_W{1'b0}}) | (w_pop & (r_count == CNT_W'(1)))) begin
        w_head_addr  = s_haddr;
        w_head_write = s_hwrite;
        w_head_size  = s_hsize;
      end else begin
        w_head_addr  = r_mem_addr[w_rptr_nxt];
        w_head_write = r_mem_write[w_rptr_nxt];
        w_head_size  = r_mem_size[w_rptr_nxt];
      end
    end else begin
      w_head_addr  = r_log_addr;
      w_head_write = r_log_write;
      w_head_size  = r_log_size;
    end
  end

  // Log FIFO storage, pointers, overflow flag and registered head view
  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int i = 0; i < LOG_DEPTH; i++) begin
        r_mem_addr[i]  <= '0;
        r_mem_write[i] <= 1'b0;
        r_mem_size[i]  <= 3'd0;
      end
      r_wptr      <= {PTR_W{1'b0}};
      r_rptr      <= {PTR_W{1'b0}};
      r_count     <= {CNT_W{1'b0}};
      r_ovf       <= 1'b0;
      r_log_addr  <= '0;
      r_log_write <= 1'b0;
      r_log_size  <= 3'd0;
    end else begin
      if (w_push & ~log_clr) begin
        r_mem_addr[r_wptr]  <= s_haddr;
        r_mem_write[r_wptr] <= s_hwrite;
        r_mem_size[r_wptr]  <= s_hsize;
      end
      r_wptr      <= w_wptr_nxt;
      r_rptr      <= w_rptr_nxt;
      r_count     <= w_count_nxt;
      if (log_clr)        r_ovf <= 1'b0;
      else if (w_ovf_set) r_ovf <= 1'b1;
      else                r_ovf <= r_ovf;
      r_log_addr  <= w_head_addr;
      r_log_write <= w_head_write;
      r_log_size  <= w_head_size;
    end
  end

  assign log_valid = (r_count != {CNT_W{1'b0}});
  assign log_addr  = r_log_addr;
  assign log_write = r_log_write;
  assign log_size  = r_log_size;
  assign log_count = r_count;
  assign log_ovf   = r_ovf;
  assign irq       = (r_count != {CNT_W{1'b0}}) | r_ovf;

endmodule
